// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if : instruction SRAM, redirect and decode-handshake signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_queue_if #(
   parameter int BR_WD = 33
);
   logic [BR_WD-1:0] br_bus;
   logic             inst_sram_en;
   logic [3:0]       inst_sram_wen;
   logic [31:0]      inst_sram_addr;
   logic [31:0]      inst_sram_wdata;
   logic [31:0]      inst_sram_rdata;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_inst;
   logic             out_adel;

   modport master (
      input  br_bus,
      input  inst_sram_rdata,
      input  out_ready,
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata,
      output out_valid,
      output out_pc,
      output out_inst,
      output out_adel
   );

   modport slave (
      output br_bus,
      output inst_sram_rdata,
      output out_ready,
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata,
      input  out_valid,
      input  out_pc,
      input  out_inst,
      input  out_adel
   );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue : instruction-fetch front end with a DEPTH-entry decode queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
   parameter int          DEPTH    = 4,
   parameter int          BR_WD    = 33
) (
   input  wire logic     clk,
   input  wire logic     resetn,
   fetch_queue_if.master bus
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w:0]    c_depth = (c_cnt_w + 1)'(DEPTH);
   localparam logic [c_ptr_w-1:0]  c_last  = c_ptr_w'(DEPTH - 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } entry_t;

   entry_t               r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_head;
   logic [c_ptr_w-1:0]   r_tail;
   logic [c_cnt_w-1:0]   r_count;
   logic [31:0]          r_fetch_pc;
   logic                 r_halted;
   logic                 r_rsp_v;
   logic [31:0]          r_rsp_pc;
   logic                 r_rsp_adel;

   logic [BR_WD-1:0]     w_br;
   logic                 w_br_e;
   logic [31:0]          w_br_addr;
   logic [c_cnt_w:0]     w_occ;
   logic                 w_issue;
   logic                 w_aligned;
   logic                 w_valid;
   logic                 w_push;
   logic                 w_pop;
   entry_t               w_head;

   assign w_br      = bus.br_bus;
   assign w_br_e    = w_br[BR_WD-1];
   assign w_br_addr = w_br[31:0];

   // The in-flight response already owns a queue slot, so it counts as occupancy
   assign w_occ     = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_rsp_v};
   assign w_issue   = !r_halted && !w_br_e && (w_occ < c_depth);
   assign w_aligned = (r_fetch_pc[1:0] == 2'b00);

   assign w_valid   = (r_count != '0);
   assign w_push    = r_rsp_v;
   assign w_pop     = w_valid && bus.out_ready;
   assign w_head    = r_mem[r_head];

   assign bus.inst_sram_en    = resetn && w_issue && w_aligned;
   assign bus.inst_sram_addr  = r_fetch_pc;
   assign bus.inst_sram_wen   = 4'b0;
   assign bus.inst_sram_wdata = 32'b0;

   assign bus.out_valid = w_valid;
   assign bus.out_pc    = w_head.pc;
   assign bus.out_inst  = w_head.inst;
   assign bus.out_adel  = w_head.adel;

   function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
      return (ptr == c_last) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fetch_pc <= RESET_PC;
         r_halted   <= 1'b0;
         r_rsp_v    <= 1'b0;
         r_rsp_pc   <= '0;
         r_rsp_adel <= 1'b0;
      end else if (w_br_e) begin
         // Redirect flushes the queue and drops the response arriving now
         r_head     <= r_tail;
         r_count    <= '0;
         r_rsp_v    <= 1'b0;
         r_halted   <= 1'b0;
         r_fetch_pc <= w_br_addr;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= '{pc:   r_rsp_pc,
                               inst: r_rsp_adel ? 32'b0 : bus.inst_sram_rdata,
                               adel: r_rsp_adel};
            r_tail <= next_ptr(r_tail);
         end
         if (w_pop) begin
            r_head <= next_ptr(r_head);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end

         if (w_issue) begin
            r_rsp_v    <= 1'b1;
            r_rsp_pc   <= r_fetch_pc;
            r_rsp_adel <= !w_aligned;
            if (w_aligned) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
               r_halted <= 1'b1;
            end
         end else if (w_push) begin
            r_rsp_v <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue : directed per-cycle vectors plus an async-reset sequence
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

   localparam logic [31:0] c_rst_pc = 32'hbfc0_0000;

   logic clk;
   logic resetn;

   fetch_queue_if #(.BR_WD(33)) bus ();

   fetch_queue #(
      .RESET_PC (c_rst_pc),
      .DEPTH    (4),
      .BR_WD    (33)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // SRAM model: one-cycle read latency, junk when no request was made
   always_ff @(posedge clk) begin
      if (bus.inst_sram_en) bus.inst_sram_rdata <= inst_of(bus.inst_sram_addr);
      else                  bus.inst_sram_rdata <= 32'hdead_beef;
   end

   typedef struct {
      logic        br_e;
      logic [31:0] br_addr;
      logic        rdy;
      logic        en;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic        adel;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp;
   int   n_bad;

   task automatic add(input logic br_e, input logic [31:0] br_addr, input logic rdy,
                      input logic en, input logic [31:0] addr,
                      input logic vld, input logic [31:0] pc, input logic adel);
      vec_t v;
      v.br_e = br_e; v.br_addr = br_addr; v.rdy = rdy;
      v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.adel = adel;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] b;
      logic [31:0] exp_inst;
      b = c_rst_pc;
      n_cmp = 0;
      n_bad = 0;

      // br_e br_addr rdy | en addr | vld pc adel
      add(0, 0, 1,  1, b+32'h00,  0, 0, 0);
      add(0, 0, 1,  1, b+32'h04,  0, 0, 0);
      add(0, 0, 1,  1, b+32'h08,  1, b+32'h00, 0);
      add(0, 0, 1,  1, b+32'h0c,  1, b+32'h04, 0);
      add(0, 0, 0,  1, b+32'h10,  1, b+32'h08, 0);
      add(0, 0, 0,  1, b+32'h14,  1, b+32'h08, 0);
      add(0, 0, 0,  0, 0,         1, b+32'h08, 0);
      add(0, 0, 0,  0, 0,         1, b+32'h08, 0);
      add(0, 0, 0,  0, 0,         1, b+32'h08, 0);
      add(0, 0, 1,  0, 0,         1, b+32'h08, 0);
      add(0, 0, 1,  1, b+32'h18,  1, b+32'h0c, 0);
      add(0, 0, 1,  1, b+32'h1c,  1, b+32'h10, 0);
      add(0, 0, 1,  1, b+32'h20,  1, b+32'h14, 0);
      add(1, 32'h8000_1000, 0,  0, 0,  1, b+32'h18, 0);
      add(0, 0, 1,  1, 32'h8000_1000,  0, 0, 0);
      add(0, 0, 1,  1, 32'h8000_1004,  0, 0, 0);
      add(0, 0, 1,  1, 32'h8000_1008,  1, 32'h8000_1000, 0);
      add(1, 32'h8000_0002, 1,  0, 0,  1, 32'h8000_1004, 0);
      add(0, 0, 1,  0, 0,  0, 0, 0);
      add(0, 0, 1,  0, 0,  0, 0, 0);
      add(0, 0, 1,  0, 0,  1, 32'h8000_0002, 1);
      add(0, 0, 1,  0, 0,  0, 0, 0);
      add(0, 0, 1,  0, 0,  0, 0, 0);
      add(1, 32'h0000_0100, 1,  0, 0,  0, 0, 0);
      add(0, 0, 1,  1, 32'h100,  0, 0, 0);
      add(0, 0, 1,  1, 32'h104,  0, 0, 0);
      add(0, 0, 1,  1, 32'h108,  1, 32'h100, 0);
      add(1, 32'h0000_0200, 1,  0, 0,  1, 32'h104, 0);
      add(1, 32'h0000_0300, 1,  0, 0,  0, 0, 0);
      add(0, 0, 1,  1, 32'h300,  0, 0, 0);
      add(0, 0, 1,  1, 32'h304,  0, 0, 0);
      add(0, 0, 1,  1, 32'h308,  1, 32'h300, 0);

      resetn = 1'b0;
      bus.br_bus = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_en",   {31'b0, bus.inst_sram_en}, 0);
      chk("rst_vld",  {31'b0, bus.out_valid}, 0);
      chk("rst_pc",   bus.out_pc, 0);
      chk("rst_inst", bus.out_inst, 0);
      chk("rst_adel", {31'b0, bus.out_adel}, 0);
      @(negedge clk);
      resetn = 1'b1;

      foreach (vecs[i]) begin
         bus.br_bus    = {vecs[i].br_e, vecs[i].br_addr};
         bus.out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d_en", i), {31'b0, bus.inst_sram_en}, {31'b0, vecs[i].en});
         if (vecs[i].en)
            chk($sformatf("v%0d_addr", i), bus.inst_sram_addr, vecs[i].addr);
         chk($sformatf("v%0d_vld", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].vld});
         if (vecs[i].vld) begin
            exp_inst = vecs[i].adel ? 32'b0 : inst_of(vecs[i].pc);
            chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].pc);
            chk($sformatf("v%0d_inst", i), bus.out_inst, exp_inst);
            chk($sformatf("v%0d_adel", i), {31'b0, bus.out_adel}, {31'b0, vecs[i].adel});
         end
         @(negedge clk);
      end

      // Asynchronous reset asserted between edges while streaming
      bus.br_bus = '0;
      bus.out_ready = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("arst_vld", {31'b0, bus.out_valid}, 0);
      chk("arst_en",  {31'b0, bus.inst_sram_en}, 0);
      chk("arst_pc",  bus.out_pc, 0);
      @(negedge clk);
      #1;
      chk("arst_en_hold", {31'b0, bus.inst_sram_en}, 0);
      resetn = 1'b1;
      #1;
      chk("rel_en",   {31'b0, bus.inst_sram_en}, 1);
      chk("rel_addr", bus.inst_sram_addr, c_rst_pc);
      @(negedge clk);
      #1;
      chk("rel_addr1", bus.inst_sram_addr, c_rst_pc + 32'd4);
      chk("rel_vld1",  {31'b0, bus.out_valid}, 0);
      @(negedge clk);
      #1;
      chk("rel_vld2",  {31'b0, bus.out_valid}, 1);
      chk("rel_pc",    bus.out_pc, c_rst_pc);
      chk("rel_inst",  bus.out_inst, inst_of(c_rst_pc));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
